conv_mac_sched: RTL and testbench

- Control-only sequencer that runs a bank of K filters through one shared MAC datapath.
- Shared datapath: X-sample buffer memory, K*F-entry filter ROM, MAC with pipeline register and ReLU output.
- Loads one X-sample frame, then computes every valid 1-D convolution output for each filter in turn.
- Emits results through a valid/ready stream tagged with filter index and position.
- Sits between the input stream source and the memory/ROM/MAC instances, replacing a per-filter FSM.

---
 rtl/conv_sched_pkg.sv | 26 ++
 rtl/conv_sched_delay.sv | 33 +++
 rtl/conv_mac_sched.sv | 190 +++++++++++++++++++
 tb/tb_conv_mac_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Purpose: shared types, constants and width helpers for the conv_mac_sched sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_sched_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   // One cycle of registered memory/ROM read plus one cycle of MAC product register.
   localparam int DRAIN_CYC = 2;

   // Width of a counter/address covering 0..n-1; never below one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter covering 0..n inclusive.
   function automatic int cw_incl(input int n);
      return cw(n + 1);
   endfunction

endpackage

// File: rtl/conv_sched_delay.sv
// Purpose: N-stage shift register turning the issue strobe into the MAC accumulate enable.
// Latency: N cycles from din to dout; clr empties every stage on the next edge.
// Backpressure: none, free-running every cycle.
// Ports: clk, clr (synchronous clear), din (issue strobe), dout (delayed strobe).
module conv_sched_delay
   import conv_sched_pkg::*;
#(
   parameter int N = DRAIN_CYC
) (
   input  logic clk,
   input  logic clr,
   input  logic din,
   output logic dout
);

   logic [N-1:0] sr_q;
   logic [N-1:0] sr_d;

   always_comb begin
      sr_d = N'({sr_q, din});
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[N-1];

endmodule

// File: rtl/conv_mac_sched.sv
// Purpose: sequences K filters over one shared MAC: load an X-sample frame, then issue F taps per output.
// Latency: first y_valid 11 cycles after the last x handshake; F+3 cycles per output with y_ready high.
// Backpressure: x_ready only in LOAD; OUT holds y_valid/y_filt/y_pos indefinitely until y_ready.
// Ports: clk/reset (sync, active-high); x_valid/x_ready/x_wr_en input stream + X memory write;
//        x_addr/f_addr memory/ROM addresses; mac_en/mac_clear MAC control;
//        y_valid/y_ready/y_filt/y_pos tagged output stream; done end-of-frame pulse.
module conv_mac_sched
   import conv_sched_pkg::*;
#(
   parameter int X = 32,
   parameter int F = 8,
   parameter int K = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               x_valid,
   output logic               x_ready,
   output logic               x_wr_en,
   output logic [cw(X)-1:0]   x_addr,
   output logic [cw(K*F)-1:0] f_addr,
   output logic               mac_en,
   output logic               mac_clear,
   output logic               y_valid,
   input  logic               y_ready,
   output logic [cw(K)-1:0]   y_filt,
   output logic [cw(X)-1:0]   y_pos,
   output logic               done
);

   localparam int AW  = cw(X);
   localparam int FAW = cw(K*F);
   localparam int KW  = cw(K);
   localparam int TW  = cw(F);

   localparam logic [AW-1:0] LD_LAST  = AW'(X - 1);
   localparam logic [AW-1:0] P_LAST   = AW'(X - F);
   localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
   localparam logic [TW-1:0] TAP_LAST = TW'(F - 1);
   localparam logic [TW-1:0] DRN_LAST = TW'(DRAIN_CYC - 1);

   state_t           state_q,   state_d;
   logic [AW-1:0]    ld_q,      ld_d;
   logic [KW-1:0]    k_q,       k_d;
   logic [AW-1:0]    p_q,       p_d;
   // tap index in ISSUE, reused as the drain cycle counter in DRAIN
   logic [TW-1:0]    tap_q,     tap_d;
   logic             x_ready_q, x_ready_d;
   logic             y_valid_q, y_valid_d;
   logic             issue_q,   issue_d;
   logic             done_q,    done_d;
   logic [AW-1:0]    x_addr_q,  x_addr_d;
   logic [FAW-1:0]   f_addr_q,  f_addr_d;

   logic x_hs;
   logic y_hs;

   assign x_hs = x_valid & x_ready_q;
   assign y_hs = y_valid_q & y_ready;

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      k_d     = k_q;
      p_d     = p_q;
      tap_d   = tap_q;
      done_d  = 1'b0;

      case (state_q)
         LOAD: begin
            if (x_hs) begin
               if (ld_q == LD_LAST) begin
                  state_d = ISSUE;
                  ld_d    = '0;
                  k_d     = '0;
                  p_d     = '0;
                  tap_d   = '0;
               end else begin
                  ld_d = ld_q + AW'(1);
               end
            end
         end
         ISSUE: begin
            if (tap_q == TAP_LAST) begin
               state_d = DRAIN;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + TW'(1);
            end
         end
         DRAIN: begin
            if (tap_q == DRN_LAST) begin
               state_d = OUT;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + TW'(1);
            end
         end
         OUT: begin
            if (y_hs) begin
               tap_d = '0;
               if (p_q == P_LAST) begin
                  p_d = '0;
                  if (k_q == K_LAST) begin
                     k_d     = '0;
                     state_d = LOAD;
                     done_d  = 1'b1;
                  end else begin
                     k_d     = k_q + KW'(1);
                     state_d = ISSUE;
                  end
               end else begin
                  p_d     = p_q + AW'(1);
                  state_d = ISSUE;
               end
            end
         end
         default: begin
            state_d = LOAD;
            ld_d    = '0;
            k_d     = '0;
            p_d     = '0;
            tap_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      x_ready_d = (state_d == LOAD);
      y_valid_d = (state_d == OUT);
      issue_d   = (state_d == ISSUE);
      x_addr_d  = '0;
      f_addr_d  = '0;
      if (state_d == LOAD) begin
         x_addr_d = ld_d;
      end else if (state_d == ISSUE) begin
         // p <= X-F and tap <= F-1, so the sum stays within the frame.
         x_addr_d = p_d + AW'(tap_d);
         f_addr_d = FAW'(k_d) * FAW'(F) + FAW'(tap_d);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOAD;
         ld_q      <= '0;
         k_q       <= '0;
         p_q       <= '0;
         tap_q     <= '0;
         x_ready_q <= 1'b1;
         y_valid_q <= 1'b0;
         issue_q   <= 1'b0;
         done_q    <= 1'b0;
         x_addr_q  <= '0;
         f_addr_q  <= '0;
      end else begin
         state_q   <= state_d;
         ld_q      <= ld_d;
         k_q       <= k_d;
         p_q       <= p_d;
         tap_q     <= tap_d;
         x_ready_q <= x_ready_d;
         y_valid_q <= y_valid_d;
         issue_q   <= issue_d;
         done_q    <= done_d;
         x_addr_q  <= x_addr_d;
         f_addr_q  <= f_addr_d;
      end
   end

   // Aligns the accumulate enable with products arriving after read + product register.
   conv_sched_delay #(
      .N (DRAIN_CYC)
   ) u_delay (
      .clk  (clk),
      .clr  (reset),
      .din  (issue_q),
      .dout (mac_en)
   );

   assign x_ready   = x_ready_q;
   assign x_wr_en   = x_hs;
   assign x_addr    = x_addr_q;
   assign f_addr    = f_addr_q;
   assign y_valid   = y_valid_q;
   assign y_filt    = k_q;
   assign y_pos     = p_q;
   assign done      = done_q;
   // Clears while loading and on every accepted output so the next output starts from zero.
   assign mac_clear = (state_q == LOAD) | y_hs | reset;

endmodule

// File: tb/tb_conv_mac_sched.sv
module tb_conv_mac_sched;

   localparam int X   = 32;
   localparam int F   = 8;
   localparam int K   = 4;
   localparam int AW  = $clog2(X);
   localparam int FAW = $clog2(K*F);
   localparam int KW  = $clog2(K);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic x_valid = 1'b0;
   logic y_ready = 1'b0;
   logic x_ready, x_wr_en, mac_en, mac_clear, y_valid, done;
   logic [AW-1:0]  x_addr;
   logic [AW-1:0]  y_pos;
   logic [FAW-1:0] f_addr;
   logic [KW-1:0]  y_filt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int hs_cyc = 0;
   int xs [X];

   always #5 clk = ~clk;

   conv_mac_sched #(.X(X), .F(F), .K(K)) dut (
      .clk       (clk),
      .reset     (reset),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .x_wr_en   (x_wr_en),
      .x_addr    (x_addr),
      .f_addr    (f_addr),
      .mac_en    (mac_en),
      .mac_clear (mac_clear),
      .y_valid   (y_valid),
      .y_ready   (y_ready),
      .y_filt    (y_filt),
      .y_pos     (y_pos),
      .done      (done)
   );

   // Attached datapath: registered X memory and ROM reads, product register, accumulator.
   logic signed [15:0] x_data = '0;
   logic signed [15:0] xmem [X];
   logic signed [15:0] rom [K*F];
   logic signed [15:0] xq, wq;
   logic signed [31:0] prod;
   logic signed [47:0] acc;
   logic [15:0]        y_data;

   always_ff @(posedge clk) begin
      if (x_wr_en) xmem[x_addr] <= x_data;
      xq <= xmem[x_addr];
      wq <= rom[f_addr];
      if (mac_clear) begin
         prod <= '0;
         acc  <= '0;
      end else begin
         prod <= xq * wq;
         if (mac_en) acc <= acc + prod;
      end
   end

   always_comb begin
      if (acc > 48'sd32767)  y_data = 16'd32767;
      else if (acc < 48'sd0) y_data = 16'd0;
      else                   y_data = acc[15:0];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (x_wr_en) wr_cnt <= wr_cnt + 1;
   end

   // Reference: direct 1-D convolution, saturated to int16, then ReLU.
   function automatic int ref_y(input int k, input int p);
      longint s = 0;
      for (int t = 0; t < F; t++) s += longint'(xs[p+t]) * longint'(rom[k*F+t]);
      if (s > 32767) return 32767;
      if (s < 0) return 0;
      return int'(s);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input bit gapped, input bit sat);
      int beat = 0;
      int w0 = wr_cnt;
      bit v;
      for (int i = 0; i < 2*X + 2 && beat < X; i++) begin
         v = gapped ? ~i[0] : 1'b1;
         x_valid = v;
         y_ready = 1'($urandom_range(0, 1));
         x_data  = sat ? 16'sd32767 : 16'($urandom_range(0, 8000) - 4000);
         #1;
         chk("ld_x_ready", x_ready, 1);
         chk("ld_wr_en", x_wr_en, v);
         chk("ld_x_addr", x_addr, beat);
         chk("ld_y_valid", y_valid, 0);
         chk("ld_mac_clear", mac_clear, 1);
         if (v) begin
            xs[beat] = x_data;
            if (beat == X-1) hs_cyc = cyc;
            beat++;
         end
         tick;
      end
      x_valid = 1'b0;
      chk("ld_wr_count", wr_cnt - w0, X);
   endtask

   task automatic do_output(input int k, input int p, input int bp, input int rst_tap,
                            input bit lat_chk, output bit aborted);
      aborted = 1'b0;
      for (int t = 0; t < F; t++) begin
         x_valid = 1'($urandom_range(0, 1));
         y_ready = 1'($urandom_range(0, 1));
         #1;
         chk("iss_x_addr", x_addr, p + t);
         chk("iss_f_addr", f_addr, k*F + t);
         chk("iss_wr_en", x_wr_en, 0);
         chk("iss_y_valid", y_valid, 0);
         chk("iss_mac_en", mac_en, t >= 2);
         chk("iss_mac_clear", mac_clear, 0);
         if (t == rst_tap) begin
            reset = 1'b1;
            tick;
            reset   = 1'b0;
            x_valid = 1'b0;
            #1;
            chk("rst_x_ready", x_ready, 1);
            chk("rst_mac_clear", mac_clear, 1);
            chk("rst_y_valid", y_valid, 0);
            chk("rst_x_addr", x_addr, 0);
            chk("rst_done", done, 0);
            chk("rst_mac_en0", mac_en, 0);
            tick;
            chk("rst_mac_en1", mac_en, 0);
            chk("rst_x_addr1", x_addr, 0);
            tick;
            chk("rst_mac_en2", mac_en, 0);
            aborted = 1'b1;
            return;
         end
         tick;
      end
      for (int d = 0; d < 2; d++) begin
         x_valid = 1'($urandom_range(0, 1));
         y_ready = 1'($urandom_range(0, 1));
         #1;
         chk("drn_y_valid", y_valid, 0);
         chk("drn_mac_en", mac_en, 1);
         chk("drn_wr_en", x_wr_en, 0);
         chk("drn_mac_clear", mac_clear, 0);
         tick;
      end
      for (int b = 0; b <= bp; b++) begin
         x_valid = 1'($urandom_range(0, 1));
         y_ready = (b == bp);
         #1;
         if (b == 0 && lat_chk) chk("first_y_latency", cyc - hs_cyc, 11);
         chk("out_y_valid", y_valid, 1);
         chk("out_y_filt", y_filt, k);
         chk("out_y_pos", y_pos, p);
         chk("out_mac_en", mac_en, 0);
         chk("out_wr_en", x_wr_en, 0);
         chk("out_mac_clear", mac_clear, b == bp);
         if (b == bp) chk("y_data", y_data, ref_y(k, p));
         tick;
      end
   endtask

   task automatic run_frame(input bit gapped, input bit sat, input bit bp_on,
                            input int rst_k, input int rst_p);
      bit ab;
      load_frame(gapped, sat);
      for (int k = 0; k < K; k++) begin
         for (int p = 0; p <= X-F; p++) begin
            int bp;
            bp = 0;
            if (bp_on) begin
               if (k == 1 && p == 3) bp = 5;
               else if ($urandom_range(0, 3) == 0) bp = $urandom_range(1, 3);
            end
            do_output(k, p, bp, (k == rst_k && p == rst_p) ? 4 : -1, k == 0 && p == 0, ab);
            if (ab) return;
         end
      end
      x_valid = 1'b0;
      y_ready = 1'($urandom_range(0, 1));
      #1;
      chk("done_pulse", done, 1);
      chk("done_x_ready", x_ready, 1);
      chk("done_y_valid", y_valid, 0);
      tick;
      chk("done_single", done, 0);
   endtask

   initial begin
      for (int k = 0; k < K; k++) begin
         for (int t = 0; t < F; t++) begin
            case (k)
               0:       rom[k*F+t] = 16'(t + 1);
               1:       rom[k*F+t] = 16'(((t % 2) != 0 ? -1 : 2) * (t + 1) * 100);
               2:       rom[k*F+t] = 16'((t * 53) % 97 - 48);
               default: rom[k*F+t] = 16'(-(t + 1));
            endcase
         end
      end

      reset   = 1'b1;
      x_valid = 1'b0;
      y_ready = 1'b0;
      repeat (3) begin
         tick;
         chk("rst_x_ready", x_ready, 1);
         chk("rst_y_valid", y_valid, 0);
         chk("rst_mac_en", mac_en, 0);
         chk("rst_done", done, 0);
         chk("rst_mac_clear", mac_clear, 1);
         chk("rst_x_addr", x_addr, 0);
         chk("rst_f_addr", f_addr, 0);
         chk("rst_y_filt", y_filt, 0);
         chk("rst_y_pos", y_pos, 0);
      end
      reset = 1'b0;

      run_frame(1'b0, 1'b0, 1'b0, -1, -1);   // back-to-back, no backpressure
      run_frame(1'b1, 1'b0, 1'b1, -1, -1);   // gapped input, backpressure incl. 5 cycles at (1,3)
      run_frame(1'b0, 1'b0, 1'b0, 0, 10);    // reset at tap 4 of output (0,10)
      run_frame(1'b0, 1'b1, 1'b1, -1, -1);   // saturating frame, restart from (0,0)

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
